// File: rtl/vram_fill_engine_m_pkg.sv
// Shared definitions for the VRAM fill engine: address width, fill-mode
// encodings and FSM state encodings.
package vram_fill_engine_m_pkg;

  localparam int VRAM_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    FILL_MODE_CONST = 2'd0,
    FILL_MODE_INCR  = 2'd1,
    FILL_MODE_ADDR  = 2'd2,
    FILL_MODE_RSVD  = 2'd3
  } fill_mode_e;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

endpackage

// File: rtl/vram_fill_engine_m_fill_pattern_gen.sv
// Per-write data word generator: latches mode/value/step on load and steps an
// accumulator on advance, so INCR needs no multiplier.
module fill_pattern_gen_m
  import vram_fill_engine_m_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [1:0]            load_mode,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic [DATA_WIDTH-1:0] load_step,
  input  logic [DATA_WIDTH-1:0] address_word,
  output logic [DATA_WIDTH-1:0] data
);

  fill_mode_e            mode_q;
  fill_mode_e            mode_sel;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] step_q;
  logic [DATA_WIDTH-1:0] acc_sel;
  logic [DATA_WIDTH-1:0] step_sel;

  // A load cycle already produces its first word, so the freshly offered
  // descriptor fields bypass the registers.
  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    mode_sel = load ? fill_mode_e'(load_mode) : mode_q;
    acc_sel  = load ? load_value : acc_q;
    step_sel = step_q;
    if (load) begin
      step_sel = (fill_mode_e'(load_mode) == FILL_MODE_INCR) ? load_step : '0;
    end
    data = (mode_sel == FILL_MODE_ADDR) ? address_word : acc_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= FILL_MODE_CONST;
      acc_q  <= '0;
      step_q <= '0;
    end else begin
      if (load) begin
        mode_q <= mode_sel;
        step_q <= step_sel;
      end
      if (load || advance) begin
        acc_q <= advance ? acc_sel + step_sel : acc_sel;
      end
    end
  end

endmodule

// File: rtl/vram_fill_engine_m.sv
// Descriptor-driven VRAM initialiser: optional boot clear, CONST/INCR/ADDR fills,
// and CPU write pass-through while idle. All outputs are registered.
module vram_fill_engine_m
  import vram_fill_engine_m_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = VRAM_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = 8,
  parameter bit                    BOOT_CLEAR  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk_12_5875,
  input  logic                  rst,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_base,
  input  logic [ADDR_WIDTH:0]   desc_len,
  input  logic [1:0]            desc_mode,
  input  logic [DATA_WIDTH-1:0] desc_value,
  input  logic [DATA_WIDTH-1:0] desc_step,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_write_enable,
  output logic [DATA_WIDTH-1:0] vram_data,
  output logic [ADDR_WIDTH-1:0] vram_address,
  output logic                  vram_write_enable,
  output logic                  in_progress,
  output logic                  done_pulse,
  output logic                  cpu_dropped
);

  localparam logic [ADDR_WIDTH:0]   FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_q;
  logic                  accept;
  logic                  gen_load;
  logic                  gen_advance;
  logic                  fill_abort;
  logic [DATA_WIDTH-1:0] base_word;
  logic [DATA_WIDTH-1:0] cnt_word;
  logic [DATA_WIDTH-1:0] gen_data;

  assign accept      = (state_q == ST_IDLE) && desc_ready && desc_valid;
  assign gen_load    = accept && (desc_len != '0);
  assign fill_abort  = (state_q == ST_FILL) && abort;
  // A same-cycle CPU write takes the first slot, so the pattern loads without stepping.
  assign gen_advance = (gen_load && !cpu_write_enable) ||
                       ((state_q == ST_FILL) && !abort && (rem_q != '0));

  if (DATA_WIDTH <= ADDR_WIDTH) begin : g_addr_trunc
    assign base_word = desc_base[DATA_WIDTH-1:0];
    assign cnt_word  = addr_q[DATA_WIDTH-1:0];
  end else begin : g_addr_zext
    assign base_word = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, desc_base};
    assign cnt_word  = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, addr_q};
  end

  fill_pattern_gen_m #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pattern (
    .clk         (clk_12_5875),
    .rst         (rst),
    .load        (gen_load),
    .advance     (gen_advance),
    .load_mode   (desc_mode),
    .load_value  (desc_value),
    .load_step   (desc_step),
    .address_word(gen_load ? base_word : cnt_word),
    .data        (gen_data)
  );

  // NOTE: state and outputs update with non-blocking assignments so every
  // register sees pre-edge values; the reset is synchronous to the pixel clock.
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      state_q           <= BOOT_CLEAR ? ST_BOOT : ST_IDLE;
      addr_q            <= '0;
      rem_q             <= FULL_LEN;
      vram_write_enable <= 1'b0;
      vram_address      <= '0;
      vram_data         <= '0;
      desc_ready        <= 1'b0;
      done_pulse        <= 1'b0;
      cpu_dropped       <= 1'b0;
      in_progress       <= BOOT_CLEAR;
    end else begin
      done_pulse <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          desc_ready        <= 1'b1;
          vram_write_enable <= cpu_write_enable;
          vram_address      <= cpu_address;
          vram_data         <= cpu_data;
          if (accept) begin
            if (desc_len == '0) begin
              done_pulse <= 1'b1;
            end else begin
              state_q     <= ST_FILL;
              desc_ready  <= 1'b0;
              in_progress <= 1'b1;
              if (cpu_write_enable) begin
                addr_q <= desc_base;
                rem_q  <= desc_len;
              end else begin
                vram_write_enable <= 1'b1;
                vram_address      <= desc_base;
                vram_data         <= gen_data;
                addr_q            <= desc_base + ADDR_ONE;
                rem_q             <= desc_len - LEN_ONE;
              end
            end
          end
        end
        default: begin
          // BOOT and FILL own VRAM; rem_q counts writes still to be presented.
          if (cpu_write_enable) begin
            cpu_dropped <= 1'b1;
          end
          if (fill_abort || (rem_q == '0)) begin
            state_q           <= ST_IDLE;
            vram_write_enable <= 1'b0;
            desc_ready        <= 1'b1;
            in_progress       <= 1'b0;
            done_pulse        <= !fill_abort;
          end else begin
            vram_write_enable <= 1'b1;
            vram_address      <= addr_q;
            vram_data         <= (state_q == ST_BOOT) ? CLEAR_VALUE : gen_data;
            addr_q            <= addr_q + ADDR_ONE;
            rem_q             <= rem_q - LEN_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_fill_engine_m.sv
// Directed bench: a 12-bit fill engine driven from a vector table, plus a
// 4-bit boot-clear engine exercised with hand-written multi-cycle sequences.
module tb_vram_fill_engine_m;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [11:0] base;
    logic [12:0] len;
    logic [1:0]  mode;
    logic [7:0]  value;
    logic [7:0]  step;
    logic        abort;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_data;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        ready;
    logic        inprog;
    logic        done;
    logic        dropped;
  } resp_t;

  typedef struct packed {
    stim_t s;
    resp_t r;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        desc_valid = 1'b0, abort = 1'b0, cpu_we = 1'b0;
  logic [11:0] desc_base = '0, cpu_addr = '0;
  logic [12:0] desc_len = '0;
  logic [1:0]  desc_mode = '0;
  logic [7:0]  desc_value = '0, desc_step = '0, cpu_data = '0;

  logic        a_ready, a_we, a_inprog, a_done, a_drop;
  logic [11:0] a_addr;
  logic [7:0]  a_data;
  logic        b_ready, b_we, b_inprog, b_done, b_drop;
  logic [3:0]  b_addr;
  logic [7:0]  b_data;

  int n_vec  = 0;
  int n_miss = 0;

  vram_fill_engine_m #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .BOOT_CLEAR(1'b0), .CLEAR_VALUE(8'h00)
  ) dut_a (
    .clk_12_5875(clk), .rst(rst_a),
    .desc_valid(desc_valid), .desc_ready(a_ready), .desc_base(desc_base),
    .desc_len(desc_len), .desc_mode(desc_mode), .desc_value(desc_value),
    .desc_step(desc_step), .abort(abort),
    .cpu_data(cpu_data), .cpu_address(cpu_addr), .cpu_write_enable(cpu_we),
    .vram_data(a_data), .vram_address(a_addr), .vram_write_enable(a_we),
    .in_progress(a_inprog), .done_pulse(a_done), .cpu_dropped(a_drop)
  );

  vram_fill_engine_m #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .BOOT_CLEAR(1'b1), .CLEAR_VALUE(8'h00)
  ) dut_b (
    .clk_12_5875(clk), .rst(rst_b),
    .desc_valid(desc_valid), .desc_ready(b_ready), .desc_base(desc_base[3:0]),
    .desc_len(desc_len[4:0]), .desc_mode(desc_mode), .desc_value(desc_value),
    .desc_step(desc_step), .abort(abort),
    .cpu_data(cpu_data), .cpu_address(cpu_addr[3:0]), .cpu_write_enable(cpu_we),
    .vram_data(b_data), .vram_address(b_addr), .vram_write_enable(b_we),
    .in_progress(b_inprog), .done_pulse(b_done), .cpu_dropped(b_drop)
  );

  function automatic stim_t s_idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t s_rst();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_desc(input logic [1:0] m, input logic [11:0] b,
                                   input logic [12:0] l, input logic [7:0] v,
                                   input logic [7:0] st);
    stim_t s = '0;
    s.valid = 1'b1;
    s.mode  = m;
    s.base  = b;
    s.len   = l;
    s.value = v;
    s.step  = st;
    return s;
  endfunction

  function automatic stim_t s_cpu(input stim_t si, input logic [11:0] a, input logic [7:0] d);
    stim_t s = si;
    s.cpu_we   = 1'b1;
    s.cpu_addr = a;
    s.cpu_data = d;
    return s;
  endfunction

  function automatic stim_t s_abort(input stim_t si);
    stim_t s = si;
    s.abort = 1'b1;
    return s;
  endfunction

  function automatic resp_t rsp(input logic we, input logic [11:0] a, input logic [7:0] d,
                                input logic rdy, input logic ip, input logic dn,
                                input logic dr);
    return resp_t'({we, a, d, rdy, ip, dn, dr});
  endfunction

  function automatic resp_t resp_a();
    return resp_t'({a_we, a_addr, a_data, a_ready, a_inprog, a_done, a_drop});
  endfunction

  function automatic resp_t resp_b();
    return resp_t'({b_we, 8'h00, b_addr, b_data, b_ready, b_inprog, b_done, b_drop});
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input stim_t s, input bit to_b);
    @(negedge clk);
    rst_a      = to_b ? 1'b1 : s.rst;
    rst_b      = to_b ? s.rst : 1'b1;
    desc_valid = s.valid;
    desc_base  = s.base;
    desc_len   = s.len;
    desc_mode  = s.mode;
    desc_value = s.value;
    desc_step  = s.step;
    abort      = s.abort;
    cpu_we     = s.cpu_we;
    cpu_addr   = s.cpu_addr;
    cpu_data   = s.cpu_data;
    @(posedge clk);
    #1;
  endtask

  // Address and data are only meaningful when a write is expected or in reset.
  task automatic check(input string name, input resp_t act, input resp_t exp, input bit chk_ad);
    resp_t a = act;
    resp_t e = exp;
    n_vec++;
    if (!chk_ad) begin
      a.addr = '0; a.data = '0;
      e.addr = '0; e.data = '0;
    end
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got we=%0b addr=%h data=%h ready=%0b inprog=%0b done=%0b dropped=%0b; expected we=%0b addr=%h data=%h ready=%0b inprog=%0b done=%0b dropped=%0b",
               name, a.we, a.addr, a.data, a.ready, a.inprog, a.done, a.dropped,
               e.we, e.addr, e.data, e.ready, e.inprog, e.done, e.dropped);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       tbl[$];
    stim_t      s;
    logic [7:0] ed;
    int         k;
    bit         got_done;

    // Main engine (12-bit, no boot clear).
    tbl.push_back(vec_t'{s_rst(),  rsp(1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)});
    tbl.push_back(vec_t'{s_rst(),  rsp(1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0)});
    // INCR wrapping in both address and data.
    tbl.push_back(vec_t'{s_desc(2'd1, 12'hFFE, 13'd4, 8'hFE, 8'h01),
                         rsp(1'b1, 12'hFFE, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b1, 12'hFFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b1, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b1, 12'h001, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0)});
    // Zero-length descriptor.
    tbl.push_back(vec_t'{s_desc(2'd0, 12'h123, 13'd0, 8'h55, 8'h00),
                         rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0)});
    // CPU pass-through in IDLE.
    tbl.push_back(vec_t'{s_cpu(s_idle(), 12'h800, 8'h0F),
                         rsp(1'b1, 12'h800, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0)});
    // CONST fill with a CPU write dropped mid-fill.
    tbl.push_back(vec_t'{s_desc(2'd0, 12'h100, 13'd3, 8'hC3, 8'h00),
                         rsp(1'b1, 12'h100, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0)});
    tbl.push_back(vec_t'{s_cpu(s_idle(), 12'h200, 8'h77),
                         rsp(1'b1, 12'h101, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b1, 12'h102, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1)});
    // CPU write and accept in the same cycle: CPU first, fill delayed one cycle.
    tbl.push_back(vec_t'{s_cpu(s_desc(2'd1, 12'h7F0, 13'd2, 8'h10, 8'h03), 12'h0AA, 8'h99),
                         rsp(1'b1, 12'h0AA, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b1, 12'h7F0, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b1, 12'h7F1, 8'h13, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1)});
    // ADDR mode aborted while the third write is presented.
    tbl.push_back(vec_t'{s_desc(2'd2, 12'h010, 13'd8, 8'h00, 8'h00),
                         rsp(1'b1, 12'h010, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b1, 12'h011, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b1, 12'h012, 8'h12, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_abort(s_idle()), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1)});
    // Abort in IDLE does not block an accept.
    tbl.push_back(vec_t'{s_abort(s_desc(2'd1, 12'h3FF, 13'd1, 8'h80, 8'h7F)),
                         rsp(1'b1, 12'h3FF, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1)});
    // Reserved mode behaves as CONST.
    tbl.push_back(vec_t'{s_desc(2'd3, 12'h020, 13'd2, 8'h5C, 8'h11),
                         rsp(1'b1, 12'h020, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b1, 12'h021, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1)});
    // Reset mid-fill clears everything including the sticky drop flag.
    tbl.push_back(vec_t'{s_desc(2'd0, 12'h400, 13'd100, 8'hEE, 8'h00),
                         rsp(1'b1, 12'h400, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b1, 12'h401, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1)});
    tbl.push_back(vec_t'{s_rst(),  rsp(1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0)});
    tbl.push_back(vec_t'{s_idle(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0)});

    foreach (tbl[i]) begin
      step(tbl[i].s, 1'b0);
      check($sformatf("vec%0d", i), resp_a(), tbl[i].r, tbl[i].r.we || tbl[i].s.rst);
    end

    // Boot clear on the 4-bit engine; a CPU write is dropped and abort ignored.
    step(s_rst(), 1'b1);
    step(s_rst(), 1'b1);
    check("b reset", resp_b(), rsp(1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    for (int i = 0; i < 16; i++) begin
      s = s_idle();
      if (i == 5) s = s_cpu(s, 12'h007, 8'h33);
      if (i == 8) s = s_abort(s);
      step(s, 1'b1);
      check($sformatf("b boot write %0d", i), resp_b(),
            rsp(1'b1, 12'(i), 8'h00, 1'b0, 1'b1, 1'b0, 1'(i >= 5)), 1'b1);
    end
    step(s_idle(), 1'b1);
    check("b boot done", resp_b(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0);
    step(s_idle(), 1'b1);
    check("b boot idle", resp_b(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0);

    // Full-length INCR fill (len = 2^AW) wrapping the address from C.
    for (int i = 0; i < 16; i++) begin
      s = (i == 0) ? s_desc(2'd1, 12'h00C, 13'd16, 8'h00, 8'h13) : s_idle();
      step(s, 1'b1);
      ed = 8'(i * 19);
      check($sformatf("b full fill %0d", i), resp_b(),
            rsp(1'b1, 12'((12 + i) % 16), ed, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);
    end
    step(s_idle(), 1'b1);
    check("b full fill done", resp_b(), rsp(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0);

    // Reset mid-fill: writes stop and the boot clear restarts at address 0.
    step(s_desc(2'd0, 12'h003, 13'd10, 8'hAB, 8'h00), 1'b1);
    check("b fill w0", resp_b(), rsp(1'b1, 12'h003, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);
    step(s_idle(), 1'b1);
    check("b fill w1", resp_b(), rsp(1'b1, 12'h004, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);
    step(s_rst(), 1'b1);
    check("b mid-fill reset", resp_b(), rsp(1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    step(s_abort(s_idle()), 1'b1);
    check("b reboot w0", resp_b(), rsp(1'b1, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    k = 1;
    got_done = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      step(s_idle(), 1'b1);
      if (b_done) begin
        got_done = 1'b1;
      end else if (b_we) begin
        check_int($sformatf("b reboot addr %0d", k), int'(b_addr), k);
        k++;
      end
    end
    check_int("b reboot done seen", int'(got_done), 1);
    check_int("b reboot write count", k, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
